seq_div_16bit: RTL and testbench

Iterative 16-bit unsigned restoring divider. It runs one shift-and-subtract step per clock and retires quotient and remainder after 16 iterations. The block sits beside the 16-bit carry-lookahead adder in the execute stage as a multi-cycle ALU unit. The core computes each trial subtraction as an add of the inverted divisor with carry-in 1, so the existing 16-bit CLA is reused as the datapath.

---
 rtl/seq_div_16bit.sv | 146 ++++++++++++++
 tb/tb_seq_div_16bit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seq_div_16bit.sv
// Iterative 16-bit unsigned restoring divider: one shift-and-subtract step per clock.
// Trial subtraction reuses a 16-bit carry-lookahead adder (a + ~b + 1).

module seq_div_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       gg,
  output logic       gp
);
  logic [3:0] g, p, c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign sum  = p ^ c;
  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gp   = &p;
endmodule

module seq_div_cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  localparam int NGRP = 4;
  logic [NGRP-1:0][3:0] a_g, b_g, s_g;
  logic [NGRP-1:0]      gg, gp, gc;

  assign a_g = a;
  assign b_g = b;
  assign sum = s_g;

  // second-level lookahead across the four nibble groups
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
  assign cout  = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) |
                 (gp[3] & gp[2] & gp[1] & gg[0]) | (&gp & cin);

  for (genvar j = 0; j < NGRP; j++) begin : g_grp
    seq_div_cla4 u_grp (
      .a   (a_g[j]),
      .b   (b_g[j]),
      .cin (gc[j]),
      .sum (s_g[j]),
      .gg  (gg[j]),
      .gp  (gp[j])
    );
  end
endmodule

module seq_div_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] dshift, dvsr, diff;
  logic [WIDTH:0]   partial;
  logic             cout, no_borrow;

  assign partial = {remainder, dshift[WIDTH-1]};

  seq_div_cla16 u_cla (
    .a    (partial[WIDTH-1:0]),
    .b    (~dvsr),
    .cin  (1'b1),
    .sum  (diff),
    .cout (cout)
  );

  // 17-bit subtract folded onto the 16-bit adder: the extended divisor's top bit is 0
  assign no_borrow = partial[WIDTH] | cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dshift      <= '0;
      dvsr        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            dshift <= dividend;
            dvsr   <= divisor;
            cnt    <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              quotient    <= '0;
              remainder   <= '0;
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state       <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          dshift    <= dshift << 1;
          remainder <= no_borrow ? diff : partial[WIDTH-1:0];
          quotient  <= {quotient[WIDTH-2:0], no_borrow};
          cnt       <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_div_16bit.sv
// Randomized scoreboard bench for seq_div_16bit: expected results come from / and %.
`timescale 1ns/1ps
module tb_seq_div_16bit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  typedef struct {
    logic [15:0] a, b, q, r;
    logic        z;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  seq_div_16bit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.a = a; e.b = b;
    if (b == 0) begin
      e.q = 16'hFFFF; e.r = a; e.z = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.z);
        if (!e.z) begin
          check("invariant", {16'd0, quotient} * {16'd0, e.b} + {16'd0, remainder}, {16'd0, e.a});
          check("rem_lt_div", 32'(remainder < e.b), 32'd1);
        end
      end
    end
  end

  // Called at a negedge; start is sampled on the next posedge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    start = 1'b1; dividend = a; divisor = b;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
    dividend = 16'($urandom); divisor = 16'($urandom);
  endtask

  // Wait for done, counting negedges; busy must stay high until then.
  task automatic wait_done(input string nm, input int exp_cyc);
    int  n = 0;
    bit  busy_bad = 0;
    while (!done && n < 40) begin
      if (!busy) busy_bad = 1;
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, n, exp_cyc);
    check({nm, "_busy_while_run"}, busy_bad, 0);
    check({nm, "_busy_at_done"}, busy, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete, expected finish before 400000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a, b;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic divide, then results held after the done pulse
    issue(16'd100, 16'd7);
    check("basic_busy_after_start", busy, 1);
    wait_done("basic", 16);
    @(negedge clk);
    check("basic_done_low", done, 0);
    check("basic_q_held", quotient, 14);
    check("basic_r_held", remainder, 2);

    // Extremes
    issue(16'hFFFF, 16'h0001); wait_done("ffff_1", 16);
    issue(16'hFFFF, 16'hFFFF); wait_done("ffff_ffff", 16);
    issue(16'd3, 16'd10);      wait_done("3_10", 16);

    // Divide by zero, then a normal divide must clear the flag
    @(negedge clk);
    issue(16'd5, 16'd0);
    wait_done("div0", 0);
    issue(16'd100, 16'd7);
    check("dbz_cleared", div_by_zero, 0);
    check("q_cleared", quotient, 0);
    wait_done("after_div0", 16);

    // Start while busy is ignored
    @(negedge clk);
    issue(16'd1000, 16'd3);
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'd7; divisor = 16'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored_start", 11);

    // Asynchronous reset mid-run discards the operation
    @(negedge clk);
    issue(16'd1234, 16'd5);
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_q", quotient, 0);
    check("midrst_r", remainder, 0);
    check("midrst_dbz", div_by_zero, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(16'd50, 16'd6);
    wait_done("after_rst", 16);

    // Back-to-back: start in the done cycle
    issue(16'd40000, 16'd123);
    wait_done("b2b", 16);

    // Random back-to-back traffic
    for (int i = 0; i < 1000; i++) begin
      int mode;
      mode = $urandom_range(0, 9);
      a = 16'($urandom);
      if (mode == 0)      b = 16'd0;
      else if (mode <= 3) b = 16'($urandom_range(1, 15));
      else                b = 16'($urandom);
      issue(a, b);
      wait_done("rand", (b == 0) ? 0 : 16);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
